// File: rtl/i2c_xfer_pkg.sv
// Shared types for the I2C transfer controller: FSM state encoding and the
// completion status codes reported alongside o_done.
package i2c_xfer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      XFER,
      STOP_WAIT,
      DONE
   } xfer_state_t;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_NACK    = 2'd1;
   localparam logic [1:0] ERR_BADREQ  = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/i2c_byte_fifo.sv
// Show-ahead byte FIFO feeding the I2C master write data; supports a
// same-cycle push+pop while full and a whole-FIFO flush.
module i2c_byte_fifo #(
   parameter int G_DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [7:0]                 din,
   input  logic                       pop,
   input  logic                       flush,
   output logic [7:0]                 dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(G_DEPTH):0]   level,
   output logic                       ovf
);
   localparam int AW = $clog2(G_DEPTH);
   localparam int LW = AW + 1;

   logic [7:0]    mem [G_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(G_DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty && !flush;
   // A pop frees a slot in the same cycle, so a push while full is still taken.
   assign do_push = push && !flush && (!full || do_pop);
   assign dout    = empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
      end else begin
         ovf <= push && !flush && !do_push;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
               2'b10:   level <= level + LW'(1);
               2'b01:   level <= level - LW'(1);
               default: level <= level;
            endcase
         end
      end
   end

endmodule

// File: rtl/i2c_xfer_ctrl.sv
// Host-side transaction controller for the I2C master: buffers write bytes,
// launches one transfer per request and reports a single completion status.
module i2c_xfer_ctrl
   import i2c_xfer_pkg::*;
#(
   parameter int G_FIFO_DEPTH     = 16,
   parameter int G_STOP_CYCLES    = 64,
   parameter int G_TIMEOUT_CYCLES = 100000
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            i_wr_push,
   input  logic [7:0]                      i_wr_byte,
   output logic                            o_wr_full,
   output logic [$clog2(G_FIFO_DEPTH):0]   o_wr_level,
   output logic                            o_wr_ovf,
   input  logic                            i_req,
   input  logic                            i_req_rw,
   input  logic [6:0]                      i_req_addr,
   input  logic [7:0]                      i_req_nb,
   output logic                            o_busy,
   output logic                            o_done,
   output logic [1:0]                      o_err_code,
   output logic [7:0]                      o_rd_byte,
   output logic                            o_rd_valid,
   output logic                            o_start,
   output logic                            o_rw,
   output logic [6:0]                      o_chip_addr,
   output logic [7:0]                      o_nb_data,
   output logic [7:0]                      o_wdata,
   input  logic [7:0]                      i_rdata,
   input  logic                            i_rdata_valid,
   input  logic                            i_next_wdata_rdy,
   input  logic                            i_sack_error
);
   localparam int SW = $clog2(G_STOP_CYCLES + 1);
   localparam int TW = $clog2(G_TIMEOUT_CYCLES + 1);

   xfer_state_t   state;
   logic [7:0]    byte_cnt;
   logic [SW-1:0] stop_cnt;
   logic [TW-1:0] to_cnt;
   logic          hs;
   logic          nack_hit;
   logic          timeout_hit;
   logic          req_bad;
   logic          fifo_pop;
   logic          fifo_flush;
   logic          fifo_empty;

   always_comb begin
      hs          = o_rw ? i_rdata_valid : i_next_wdata_rdy;
      nack_hit    = i_sack_error && (state == START || state == XFER || state == STOP_WAIT);
      timeout_hit = (state == XFER) && !hs && (to_cnt == TW'(G_TIMEOUT_CYCLES - 1));
      // Validity uses the registered level, so a same-cycle push cannot rescue a short request.
      req_bad     = (i_req_nb == 8'd0) || (!i_req_rw && ({1'b0, i_req_nb} > 9'(o_wr_level)));
      fifo_pop    = (state == XFER) && !o_rw && i_next_wdata_rdy && !fifo_empty;
      fifo_flush  = nack_hit || timeout_hit;
   end

   i2c_byte_fifo #(.G_DEPTH(G_FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (i_wr_push),
      .din   (i_wr_byte),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .dout  (o_wdata),
      .full  (o_wr_full),
      .empty (fifo_empty),
      .level (o_wr_level),
      .ovf   (o_wr_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         o_start     <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_err_code  <= ERR_OK;
         o_rd_byte   <= 8'h00;
         o_rd_valid  <= 1'b0;
         o_rw        <= 1'b0;
         o_chip_addr <= 7'h00;
         o_nb_data   <= 8'h00;
         byte_cnt    <= 8'h00;
         stop_cnt    <= '0;
         to_cnt      <= '0;
      end else begin
         o_start    <= 1'b0;
         o_done     <= 1'b0;
         o_rd_valid <= 1'b0;
         if (nack_hit) begin
            state      <= DONE;
            o_done     <= 1'b1;
            o_err_code <= ERR_NACK;
         end else begin
            case (state)
               IDLE: begin
                  if (i_req) begin
                     o_rw        <= i_req_rw;
                     o_chip_addr <= i_req_addr;
                     o_nb_data   <= i_req_nb;
                     if (req_bad) begin
                        state      <= DONE;
                        o_done     <= 1'b1;
                        o_err_code <= ERR_BADREQ;
                     end else begin
                        state    <= START;
                        o_start  <= 1'b1;
                        o_busy   <= 1'b1;
                        byte_cnt <= 8'h00;
                        to_cnt   <= '0;
                     end
                  end
               end
               START: state <= XFER;
               XFER: begin
                  if (timeout_hit) begin
                     state      <= DONE;
                     o_done     <= 1'b1;
                     o_err_code <= ERR_TIMEOUT;
                  end else if (hs) begin
                     to_cnt   <= '0;
                     byte_cnt <= byte_cnt + 8'd1;
                     if (o_rw) begin
                        o_rd_byte  <= i_rdata;
                        o_rd_valid <= 1'b1;
                     end
                     if (byte_cnt + 8'd1 == o_nb_data) begin
                        state    <= STOP_WAIT;
                        stop_cnt <= '0;
                     end
                  end else begin
                     to_cnt <= to_cnt + TW'(1);
                  end
               end
               STOP_WAIT: begin
                  if (stop_cnt == SW'(G_STOP_CYCLES - 1)) begin
                     state      <= DONE;
                     o_done     <= 1'b1;
                     o_err_code <= ERR_OK;
                  end else begin
                     stop_cnt <= stop_cnt + SW'(1);
                  end
               end
               DONE: begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
// Bench for i2c_xfer_ctrl: a queue-based FIFO model plus a transaction-level
// master that predicts status, timing and data for table and random transfers.
module tb_i2c_xfer_ctrl;
   localparam int DEPTH = 8;
   localparam int STOPC = 8;
   localparam int TOC   = 40;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_wr_push, i_req, i_req_rw, i_rdata_valid, i_next_wdata_rdy, i_sack_error;
   logic [7:0]    i_wr_byte, i_req_nb, i_rdata;
   logic [6:0]    i_req_addr;
   logic          o_wr_full, o_wr_ovf, o_busy, o_done, o_rd_valid, o_start, o_rw;
   logic [LW-1:0] o_wr_level;
   logic [1:0]    o_err_code;
   logic [7:0]    o_rd_byte, o_nb_data, o_wdata;
   logic [6:0]    o_chip_addr;

   int errors = 0;
   int checks = 0;
   logic [7:0] mq[$];

   typedef struct {
      bit         rw;
      logic [6:0] addr;
      logic [7:0] nb;
      int         npush;
      logic [31:0] bytes;
      int         sack_after;
      bit         silent;
      logic [1:0] err;
   } vec_t;
   vec_t tbl[9];

   always #5 clk = ~clk;

   i2c_xfer_ctrl #(.G_FIFO_DEPTH(DEPTH), .G_STOP_CYCLES(STOPC), .G_TIMEOUT_CYCLES(TOC)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_wr_push(i_wr_push), .i_wr_byte(i_wr_byte), .o_wr_full(o_wr_full),
      .o_wr_level(o_wr_level), .o_wr_ovf(o_wr_ovf),
      .i_req(i_req), .i_req_rw(i_req_rw), .i_req_addr(i_req_addr), .i_req_nb(i_req_nb),
      .o_busy(o_busy), .o_done(o_done), .o_err_code(o_err_code),
      .o_rd_byte(o_rd_byte), .o_rd_valid(o_rd_valid),
      .o_start(o_start), .o_rw(o_rw), .o_chip_addr(o_chip_addr), .o_nb_data(o_nb_data),
      .o_wdata(o_wdata), .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid),
      .i_next_wdata_rdy(i_next_wdata_rdy), .i_sack_error(i_sack_error)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One clock cycle: master/host controls are set by the caller beforehand.
   task automatic step(input bit push, input logic [7:0] b, input bit pop, input bit flush);
      int sz;
      bit pp;
      bit exp_ovf;
      i_wr_push = push;
      i_wr_byte = b;
      @(posedge clk);
      #1;
      i_wr_push = 1'b0; i_req = 1'b0; i_next_wdata_rdy = 1'b0;
      i_rdata_valid = 1'b0; i_sack_error = 1'b0;
      sz = mq.size();
      pp = pop && (sz > 0);
      exp_ovf = 1'b0;
      if (flush) mq.delete();
      else begin
         if (pp) void'(mq.pop_front());
         if (push) begin
            if (sz < DEPTH || pp) mq.push_back(b);
            else exp_ovf = 1'b1;
         end
      end
      chk("level", 32'(o_wr_level), mq.size());
      chk("full", 32'(o_wr_full), 32'(mq.size() == DEPTH));
      chk("ovf", 32'(o_wr_ovf), 32'(exp_ovf));
      chk("wdata", 32'(o_wdata), mq.size() > 0 ? 32'(mq[0]) : 32'h0);
   endtask

   function automatic bit want_push(input int pmode, input bit is_pop);
      if (pmode == 1) return ($urandom_range(0, 2) == 0);
      if (pmode == 2) return is_pop;
      return 1'b0;
   endfunction

   task automatic run_xfer(input bit rw, input logic [6:0] addr, input logic [7:0] nb,
                           input int sack_after, input bit silent, input int pmode,
                           input logic [31:0] rbytes, input logic [1:0] exp_err);
      bit bad;
      bit early;
      logic [7:0] rb;
      bad = (nb == 8'd0) || (!rw && int'(nb) > mq.size());
      i_req = 1'b1; i_req_rw = rw; i_req_addr = addr; i_req_nb = nb;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      i_req_rw = $urandom_range(0, 1); i_req_addr = 7'($urandom); i_req_nb = 8'($urandom);
      chk("rw_latch", 32'(o_rw), 32'(rw));
      chk("addr_latch", 32'(o_chip_addr), 32'(addr));
      chk("nb_latch", 32'(o_nb_data), 32'(nb));
      if (bad) begin
         chk("bad_start", 32'(o_start), 0);
         chk("bad_done", 32'(o_done), 1);
         chk("bad_err", 32'(o_err_code), 32'(exp_err));
         step(1'b0, 8'h00, 1'b0, 1'b0);
         chk("bad_done_fall", 32'(o_done), 0);
         return;
      end
      chk("start_pulse", 32'(o_start), 1);
      chk("start_busy", 32'(o_busy), 1);
      step(want_push(pmode, 1'b0), 8'($urandom), 1'b0, 1'b0);
      chk("start_fall", 32'(o_start), 0);
      if (silent) begin
         early = 1'b0;
         for (int n = 2; n <= TOC + 1; n++) begin
            step(1'b0, 8'h00, 1'b0, n == TOC + 1);
            if (n <= TOC && o_done) early = 1'b1;
         end
         chk("to_early", 32'(early), 0);
         chk("to_done", 32'(o_done), 1);
         chk("to_err", 32'(o_err_code), 32'(exp_err));
      end else begin
         for (int i = 0; i < int'(nb); i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--)
               step(want_push(pmode, 1'b0), 8'($urandom), 1'b0, 1'b0);
            if (i == sack_after) begin
               i_sack_error = 1'b1;
               step(1'b0, 8'h00, 1'b0, 1'b1);
               chk("nack_done", 32'(o_done), 1);
               chk("nack_err", 32'(o_err_code), 32'(exp_err));
               step(1'b0, 8'h00, 1'b0, 1'b0);
               chk("nack_busy", 32'(o_busy), 0);
               return;
            end
            if (!rw) begin
               i_next_wdata_rdy = 1'b1;
               step(want_push(pmode, 1'b1), 8'($urandom), 1'b1, 1'b0);
            end else begin
               rb = (i < 4) ? rbytes[8*i +: 8] : 8'($urandom);
               i_rdata = rb; i_rdata_valid = 1'b1;
               step(want_push(pmode, 1'b0), 8'($urandom), 1'b0, 1'b0);
               chk("rd_valid", 32'(o_rd_valid), 1);
               chk("rd_byte", 32'(o_rd_byte), 32'(rb));
            end
         end
         if (sack_after == int'(nb)) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            i_sack_error = 1'b1;
            step(1'b0, 8'h00, 1'b0, 1'b1);
            chk("nack_sw_done", 32'(o_done), 1);
            chk("nack_sw_err", 32'(o_err_code), 32'(exp_err));
         end else begin
            early = 1'b0;
            for (int n = 1; n <= STOPC; n++) begin
               step(want_push(pmode, 1'b0), 8'($urandom), 1'b0, 1'b0);
               if (n < STOPC && o_done) early = 1'b1;
               if (n == 2) chk("rd_valid_fall", 32'(o_rd_valid), 0);
            end
            chk("stop_early", 32'(early), 0);
            chk("ok_done", 32'(o_done), 1);
            chk("ok_err", 32'(o_err_code), 32'(exp_err));
            chk("ok_busy_in_done", 32'(o_busy), 1);
         end
      end
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_busy", 32'(o_busy), 0);
      chk("idle_done", 32'(o_done), 0);
      chk("err_hold", 32'(o_err_code), 32'(exp_err));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] nb;
      bit rw;
      int sa;
      bit bad;
      rst_n = 1'b0; i_wr_push = 1'b0; i_wr_byte = 8'h00; i_req = 1'b0; i_req_rw = 1'b0;
      i_req_addr = 7'h00; i_req_nb = 8'h00; i_rdata = 8'h00; i_rdata_valid = 1'b0;
      i_next_wdata_rdy = 1'b0; i_sack_error = 1'b0;

      tbl[0] = '{1'b0, 7'h50, 8'd3, 3, 32'h007E3CA5, -1, 1'b0, 2'd0};
      tbl[1] = '{1'b1, 7'h68, 8'd2, 0, 32'h00002211, -1, 1'b0, 2'd0};
      tbl[2] = '{1'b0, 7'h22, 8'd4, 2, 32'h00000201, -1, 1'b0, 2'd2};
      tbl[3] = '{1'b1, 7'h10, 8'd0, 0, 32'h0,        -1, 1'b0, 2'd2};
      tbl[4] = '{1'b0, 7'h33, 8'd3, 3, 32'h00C0B0A0,  1, 1'b0, 2'd1};
      tbl[5] = '{1'b0, 7'h44, 8'd1, 1, 32'h0000005A, -1, 1'b1, 2'd3};
      tbl[6] = '{1'b0, 7'h45, 8'd0, 0, 32'h0,        -1, 1'b0, 2'd2};
      tbl[7] = '{1'b1, 7'h3A, 8'd1, 2, 32'h00009988,  0, 1'b0, 2'd1};
      tbl[8] = '{1'b1, 7'h29, 8'd2, 0, 32'h00004433,  2, 1'b0, 2'd1};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_start", 32'(o_start), 0);
      chk("rst_level", 32'(o_wr_level), 0);
      chk("rst_wdata", 32'(o_wdata), 0);
      chk("rst_err", 32'(o_err_code), 0);
      chk("rst_rdv", 32'(o_rd_valid), 0);
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0);

      foreach (tbl[t]) begin
         for (int k = 0; k < tbl[t].npush; k++)
            step(1'b1, (k < 4) ? tbl[t].bytes[8*k +: 8] : 8'($urandom), 1'b0, 1'b0);
         run_xfer(tbl[t].rw, tbl[t].addr, tbl[t].nb, tbl[t].sack_after, tbl[t].silent,
                  0, tbl[t].bytes, tbl[t].err);
      end

      // Fill, overflow, then drain with a push on every pop while full.
      while (mq.size() < DEPTH) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b0);
      run_xfer(1'b0, 7'h51, 8'(DEPTH), -1, 1'b0, 2, 32'h0, 2'd0);
      run_xfer(1'b0, 7'h52, 8'(DEPTH), -1, 1'b0, 0, 32'h0, 2'd0);

      // Handshakes and NACK outside a transfer are ignored.
      step(1'b1, 8'h77, 1'b0, 1'b0);
      i_next_wdata_rdy = 1'b1; step(1'b0, 8'h00, 1'b0, 1'b0);
      i_sack_error = 1'b1;     step(1'b0, 8'h00, 1'b0, 1'b0);
      i_rdata_valid = 1'b1;    step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_rdv", 32'(o_rd_valid), 0);
      chk("idle_nodone", 32'(o_done), 0);

      // Reset in the middle of a write transfer.
      step(1'b1, 8'h78, 1'b0, 1'b0);
      i_req = 1'b1; i_req_rw = 1'b0; i_req_addr = 7'h12; i_req_nb = 8'd2;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      i_req = 1'b1; i_req_addr = 7'h7F; i_req_nb = 8'd1;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("busy_req_ignored", 32'(o_chip_addr), 32'h12);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(o_busy), 0);
      chk("mid_rst_addr", 32'(o_chip_addr), 0);
      chk("mid_rst_nb", 32'(o_nb_data), 0);
      chk("mid_rst_level", 32'(o_wr_level), 0);
      chk("mid_rst_wdata", 32'(o_wdata), 0);
      for (int r = 0; r < 3; r++) begin
         i_next_wdata_rdy = 1'b1;
         @(posedge clk);
         #1;
         chk("mid_rst_nodone", 32'(o_done), 0);
      end
      i_next_wdata_rdy = 1'b0;
      mq.delete();
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("post_rst_done", 32'(o_done), 0);
      chk("post_rst_busy", 32'(o_busy), 0);

      // Randomised transfers against the model.
      for (int t = 0; t < 14; t++) begin
         for (int k = $urandom_range(0, DEPTH + 1); k > 0; k--)
            step(1'b1, 8'($urandom), 1'b0, 1'b0);
         rw = $urandom_range(0, 1);
         nb = rw ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, DEPTH + 1));
         sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(nb)) : -1;
         bad = (nb == 8'd0) || (!rw && int'(nb) > mq.size());
         run_xfer(rw, 7'($urandom), nb, sa, 1'b0, 1, 32'($urandom),
                  bad ? 2'd2 : (sa >= 0 ? 2'd1 : 2'd0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
